// File: rtl/core_pkg.sv
// Shared fetch-stage types and defaults: reset/NOP constants, the fetched word record,
// and the output-register source selection.
package core_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSN_DEFAULT = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] pc;
  } fetch_word_t;

  // Source feeding the decoder-facing output register on the next edge.
  typedef enum logic [2:0] {
    OUT_HOLD,
    OUT_FLUSH,
    OUT_DRAIN,
    OUT_RETURN,
    OUT_EMPTY
  } out_sel_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Synchronous instruction-memory read port: strobe and word address out, data back one cycle later.
interface fetch_unit_if;

  logic        imem_re;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;

  modport master (
    output imem_re,
    output imem_addr,
    input  imem_rdata
  );

  modport slave (
    input  imem_re,
    input  imem_addr,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding a fetched word that arrived while the output was stalled.
module fetch_skid_buf
  import core_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        load,
  input  logic        drain,
  input  fetch_word_t din,
  output fetch_word_t dout,
  output logic        valid
);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dout <= '0;
    end else if (load) begin
      dout <= din;
    end
  end

  // Issue is suppressed while the output is held, so a second word can never arrive here.
  skid_no_overflow: assert property (
    @(posedge clk) disable iff (reset) !(load && valid && !drain && !flush)
  );

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC and read issue, registered insn/pc/valid output to the decoder,
// a one-entry skid for stalls, and flush/refetch on redirect.
module fetch_unit
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSN = NOP_INSN_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                stall,
  input  logic                redirect,
  input  logic [31:0]         redirect_pc,
  fetch_unit_if.master        imem,
  output logic [31:0]         insn,
  output logic [31:0]         pc,
  output logic                insn_valid
);

  logic [31:0] fetch_pc;
  logic [31:0] pend_pc;
  logic        pend;
  logic        issue;
  logic [31:0] issue_addr;
  logic        held;
  logic        skid_load;
  logic        skid_drain;
  logic        skid_valid;
  fetch_word_t skid_word;
  fetch_word_t ret_word;
  out_sel_e    out_sel;

  // Issue is masked during reset so the first read goes out the cycle reset drops.
  always_comb begin
    issue      = !reset && (redirect || (run && !stall));
    issue_addr = redirect ? word_align(redirect_pc) : fetch_pc;
  end

  assign imem.imem_re   = issue;
  assign imem.imem_addr = issue_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= word_align(RESET_PC);
      pend     <= 1'b0;
      pend_pc  <= '0;
    end else begin
      pend <= issue;
      if (issue) begin
        fetch_pc <= issue_addr + 32'd4;
        pend_pc  <= issue_addr;
      end
    end
  end

  always_comb begin
    held          = insn_valid && stall;
    ret_word.insn = imem.imem_rdata;
    ret_word.pc   = pend_pc;
  end

  // Redirect outranks everything; a returning word goes to the skid only when the output is held.
  always_comb begin
    out_sel = OUT_HOLD;
    if (redirect) begin
      out_sel = OUT_FLUSH;
    end else if (skid_valid && !stall) begin
      out_sel = OUT_DRAIN;
    end else if (pend && !held) begin
      out_sel = OUT_RETURN;
    end else if (insn_valid && !stall) begin
      out_sel = OUT_EMPTY;
    end
  end

  always_comb begin
    skid_load  = !redirect && pend && held;
    skid_drain = (out_sel == OUT_DRAIN);
  end

  fetch_skid_buf u_skid (
    .clk   (clk),
    .reset (reset),
    .flush (redirect),
    .load  (skid_load),
    .drain (skid_drain),
    .din   (ret_word),
    .dout  (skid_word),
    .valid (skid_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      insn       <= NOP_INSN;
      pc         <= word_align(RESET_PC);
      insn_valid <= 1'b0;
    end else begin
      unique case (out_sel)
        OUT_FLUSH, OUT_EMPTY: begin
          insn       <= NOP_INSN;
          insn_valid <= 1'b0;
        end
        OUT_DRAIN: begin
          insn       <= skid_word.insn;
          pc         <= skid_word.pc;
          insn_valid <= 1'b1;
        end
        OUT_RETURN: begin
          insn       <= ret_word.insn;
          pc         <= ret_word.pc;
          insn_valid <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed stimulus, a queue-based model of delivered words checked every
// cycle, and literal expectations for the key scenarios.
module tb_fetch_unit;
  import core_pkg::*;

  localparam logic [31:0] RPC  = 32'h0000_0100;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] SALT = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] insn;
  logic [31:0] pc;
  logic        insn_valid;

  int checks = 0;
  int failures = 0;

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC (RPC),
    .NOP_INSN (NOP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (bus),
    .insn        (insn),
    .pc          (pc),
    .insn_valid  (insn_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.imem_re) bus.imem_rdata <= bus.imem_addr ^ SALT;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: words become visible two cycles after issue, in order, and leave when accepted.
  logic [31:0] fifo[$];
  logic [31:0] acc[$];
  logic        m_ready = 1'b0;
  logic        m_infl = 1'b0;
  logic [31:0] m_infl_pc = '0;
  logic [31:0] m_fpc = '0;

  always @(negedge clk) begin
    logic        exp_re;
    logic [31:0] exp_addr;
    exp_re   = !reset && (redirect || (run && !stall));
    exp_addr = redirect ? (redirect_pc & ~32'h3) : m_fpc;
    if (m_ready) begin
      chk("imem_re", {31'b0, bus.imem_re}, {31'b0, exp_re});
      if (exp_re) chk("imem_addr", bus.imem_addr, exp_addr);
      chk("insn_valid", {31'b0, insn_valid}, {31'b0, fifo.size() != 0});
      if (fifo.size() != 0) begin
        chk("pc", pc, fifo[0]);
        chk("insn", insn, fifo[0] ^ SALT);
      end else begin
        chk("insn_nop", insn, NOP);
      end
      if (fifo.size() > 2) begin
        checks++;
        failures++;
        $display("FAIL model_depth: got %0d expected <=2", fifo.size());
      end
      if (!reset && !stall && fifo.size() != 0) acc.push_back(fifo[0]);
    end
    if (reset) begin
      fifo.delete();
      m_infl  = 1'b0;
      m_fpc   = RPC;
      m_ready = 1'b1;
    end else if (m_ready) begin
      if (redirect) begin
        fifo.delete();
      end else begin
        if (!stall && fifo.size() != 0) void'(fifo.pop_front());
        if (m_infl) fifo.push_back(m_infl_pc);
      end
      m_infl = exp_re;
      if (exp_re) begin
        m_infl_pc = exp_addr;
        m_fpc     = exp_addr + 32'd4;
      end
    end
  end

  task automatic drive(input logic r, input logic rn, input logic st, input logic rd,
                       input logic [31:0] rp);
    @(posedge clk);
    #1;
    reset       = r;
    run         = rn;
    stall       = st;
    redirect    = rd;
    redirect_pc = rp;
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_acc[16];
    exp_acc = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110, 32'h200, 32'h204, 32'h300,
                32'h304, 32'hFFFF_FFFC, 32'h0, 32'h100, 32'h104, 32'h108, 32'h10C, 32'h110};

    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    // C0..C3: streaming after reset
    drive(0, 1, 0, 0, 0);
    chk("rst_valid", {31'b0, insn_valid}, 32'd0);
    chk("rst_insn", insn, NOP);
    chk("rst_pc", pc, RPC);
    chk("c0_addr", bus.imem_addr, 32'h100);
    drive(0, 1, 0, 0, 0);
    chk("c1_addr", bus.imem_addr, 32'h104);
    drive(0, 1, 0, 0, 0);
    chk("c2_addr", bus.imem_addr, 32'h108);
    chk("c2_pc", pc, 32'h100);
    drive(0, 1, 0, 0, 0);
    // C4..C6: stall while 0x108 presented
    drive(0, 1, 1, 0, 0);
    chk("stall_pc", pc, 32'h108);
    drive(0, 1, 1, 0, 0);
    chk("stall_re", {31'b0, bus.imem_re}, 32'd0);
    chk("stall_pc_held", pc, 32'h108);
    drive(0, 1, 1, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    chk("drain_pc", pc, 32'h10C);
    // C9: redirect with 0x114 in flight
    drive(0, 1, 0, 1, 32'h200);
    drive(0, 1, 0, 0, 0);
    chk("redir_bubble", {31'b0, insn_valid}, 32'd0);
    drive(0, 1, 0, 0, 0);
    chk("redir_pc", pc, 32'h200);
    drive(0, 1, 0, 0, 0);
    // C13..C16: redirect during stall with full skid
    drive(0, 1, 1, 0, 0);
    drive(0, 1, 1, 1, 32'h303);
    chk("redir_stall_addr", bus.imem_addr, 32'h300);
    drive(0, 1, 1, 0, 0);
    drive(0, 1, 1, 0, 0);
    chk("redir_stall_pc", pc, 32'h300);
    chk("redir_stall_valid", {31'b0, insn_valid}, 32'd1);
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    // C19..C22: wrap at top of address space
    drive(0, 1, 0, 1, 32'hFFFF_FFFC);
    drive(0, 1, 0, 0, 0);
    chk("wrap_addr", bus.imem_addr, 32'h0);
    drive(0, 1, 0, 0, 0);
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    drive(0, 1, 0, 0, 0);
    // C23: reset with a read in flight
    drive(1, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    chk("rst2_valid", {31'b0, insn_valid}, 32'd0);
    chk("rst2_insn", insn, NOP);
    chk("rst2_pc", pc, RPC);
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    // C27..C28: run low, in-flight word completes
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk("runlow_re", {31'b0, bus.imem_re}, 32'd0);
    chk("runlow_pc", pc, 32'h108);
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    @(negedge clk);
    #1;

    chk("acc_count", acc.size(), 32'd16);
    for (int i = 0; i < 16; i++) begin
      if (i < acc.size()) chk($sformatf("acc[%0d]", i), acc[i], exp_acc[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
